// File: rtl/srl16_fifo_ctrl.sv
// srl16_fifo_ctrl: ready/valid FIFO controller around an external bank of WIDTH SRL16E primitives
// Ports: CLK clock, RST sync active-high reset; S_DATA/S_VALID/S_READY upstream stream;
//   M_DATA/M_VALID/M_READY registered downstream stream; SRL_D/SRL_CE/SRL_A shift data, shift enable
//   and read address to the bank, SRL_Q bank outputs; LEVEL entries held (0..17); AFULL LEVEL >= AFULL_LVL.
// Define SRL16_FIFO_BYPASS_EN to load a word arriving at an empty FIFO straight into M_DATA.
module srl16_fifo_ctrl #(
  parameter int WIDTH = 8,
  parameter int AFULL_LVL = 12
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] S_DATA,
  input  logic             S_VALID,
  output logic             S_READY,
  output logic [WIDTH-1:0] M_DATA,
  output logic             M_VALID,
  input  logic             M_READY,
  output logic [WIDTH-1:0] SRL_D,
  output logic             SRL_CE,
  output logic [3:0]       SRL_A,
  input  logic [WIDTH-1:0] SRL_Q,
  output logic [4:0]       LEVEL,
  output logic             AFULL
);
  localparam logic [4:0] AF = 5'(AFULL_LVL);
  logic [4:0] cnt, cnt_nxt, level_nxt, cnt_m1;
  logic out_v, out_v_nxt, push, pop, byp, shift;
  assign S_READY = !RST && cnt < 5'd16;
  assign push = S_VALID && S_READY;
  // the oldest SRL entry sits at index cnt-1; output stage refills whenever it is empty or draining
  assign pop = cnt != 5'd0 && (!out_v || M_READY);
`ifdef SRL16_FIFO_BYPASS_EN
  assign byp = push && cnt == 5'd0 && (!out_v || M_READY);
`else
  assign byp = 1'b0;
`endif
  assign shift = push && !byp;
  assign cnt_m1 = cnt - 5'd1;
  assign SRL_CE = shift;
  assign SRL_D = S_DATA;
  assign SRL_A = cnt == 5'd0 ? 4'h0 : cnt_m1[3:0];
  assign M_VALID = out_v;
  always_comb begin
    cnt_nxt = cnt + {4'd0, shift} - {4'd0, pop};
    out_v_nxt = (pop || byp) ? 1'b1 : (M_READY ? 1'b0 : out_v);
    level_nxt = cnt_nxt + {4'd0, out_v_nxt};
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= 5'd0;
      out_v <= 1'b0;
      LEVEL <= 5'd0;
      AFULL <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      out_v <= out_v_nxt;
      LEVEL <= level_nxt;
      AFULL <= level_nxt >= AF;
    end
  end
  // SRL_Q is read before the shift lands, so a simultaneous push cannot corrupt the popped word
  always_ff @(posedge CLK) begin
    if (!RST && (pop || byp)) M_DATA <= pop ? SRL_Q : S_DATA;
  end
endmodule

// File: doc/srl16_fifo_ctrl.md
Name: srl16_fifo_ctrl

Overview:
- Occupancy/address controller that turns a bank of WIDTH external 16-deep SRL16E primitives into a shallow ready/valid FIFO.
- Drives the shared CE, the 4-bit address and the per-bit shift data of the SRL bank. Captures the bank's Q outputs into a registered output stage.
- Sits between a streaming producer and consumer where a cheap, LUT-based elastic buffer of up to 17 entries is required.

Parameters:
- WIDTH, 8, data width and number of SRL16E instances in the bank.
- AFULL_LVL, 12, LEVEL value at or above which AFULL asserts; legal range 1..17.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- S_DATA  input  WIDTH  upstream data.
- S_VALID  input  1  upstream data valid.
- S_READY  output  1  block accepts S_DATA this cycle.
- M_DATA  output  WIDTH  head-of-FIFO data, registered.
- M_VALID  output  1  M_DATA valid.
- M_READY  input  1  downstream accepts M_DATA.
- SRL_D  output  WIDTH  shift-in data to the SRL bank; equals S_DATA.
- SRL_CE  output  1  shift enable to the SRL bank.
- SRL_A  output  4  read address to the SRL bank.
- SRL_Q  input  WIDTH  SRL bank outputs.
- LEVEL  output  5  total entries held (SRL entries + output register), 0..17.
- AFULL  output  1  LEVEL >= AFULL_LVL.

Behaviour:
- Internal state:
  - cnt[4:0]: SRL occupancy, 0..16.
  - out_v: output register valid.
  - M_DATA register.
- Reset: cnt=0, out_v=0, M_VALID=0, S_READY=0, SRL_CE=0, LEVEL=0, AFULL=0. M_DATA keeps its previous value.
  - SRL contents are not reset; cnt=0 marks them invalid.
  - Reset mid-operation discards all held data. No push or pop takes effect in a cycle where RST=1.
- S_READY = !RST && (cnt < 16).
- push = S_VALID && S_READY.
- SRL_CE = push. SRL_D = S_DATA, combinational.
- SRL_A = cnt-1 when cnt>0, else 4'h0. The oldest entry sits at index cnt-1.
- pop = (cnt > 0) && (!out_v || M_READY).
  - On pop, M_DATA <= SRL_Q and out_v <= 1.
  - SRL_Q is sampled pre-shift, so a push in the same cycle is harmless.
- If M_READY && out_v && !pop, then out_v <= 0.
- Count update: cnt_next = cnt + push - pop; push and pop in the same cycle leave cnt unchanged.
- M_VALID = out_v.
- LEVEL = cnt + out_v, registered from next-state values so that it matches the post-edge state.
- AFULL is registered alongside LEVEL.
- Latency: an S_DATA word accepted at edge N reaches M_VALID=1 at edge N+1 when the FIFO was empty, i.e. 2 cycles from presentation.
- Full condition: cnt=16 forces S_READY=0 even if a pop occurs that cycle. No combinational path from M_READY to S_READY.
- Empty condition: cnt=0 gives no pop and SRL_A=0. Q is ignored.
- Ordering: strict FIFO; no word is lost or duplicated under any M_READY/S_VALID pattern.
- Downstream may deassert M_READY at any time; M_DATA holds stable while M_VALID && !M_READY.

Optional Feature:
- Macro SRL16_FIFO_BYPASS_EN.
- When defined: if cnt=0 and (!out_v || M_READY) and push, then S_DATA loads directly into M_DATA and out_v<=1.
  - In that cycle SRL_CE=0 and cnt stays 0.
  - Empty-FIFO latency drops to 1 edge.
- When undefined: every word passes through the SRL bank; latency is as stated in Behaviour.
- All other rules are identical in both builds; LEVEL counts a bypassed word as 1.

Test Plan:
- Reset, then S_VALID=1, S_DATA=0xA5 for one cycle, M_READY=1 -> SRL_CE=1 at edge 1; M_VALID=1, M_DATA=0xA5 at edge 2 (edge 1 with BYPASS_EN); LEVEL returns to 0 after the pop.
- M_READY=0; push 0x00..0x10 back to back -> S_READY deasserts after 17 accepted words (16 in SRL + 1 in output register); LEVEL=17, AFULL=1 from LEVEL=12.
- Full FIFO, then M_READY=1 continuously with no new input -> outputs 0x00..0x10 in order on consecutive cycles; final LEVEL=0, M_VALID=0.
- Steady stream with S_VALID=1 and M_READY=1, random 8-bit data for 100 cycles -> output sequence equals input; cnt stays at 1 (0 with BYPASS_EN).
- M_READY toggling pseudo-randomly and S_VALID toggling independently, 1000 words -> scoreboard match, no loss or duplication, M_DATA stable while stalled.
- Reset asserted for 1 cycle with LEVEL=9 -> next cycle M_VALID=0, LEVEL=0, S_READY=1; a subsequent push of 0x3C emerges first.
